decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Stage directly upstream of the ALU in the 8-bit processor.
- Accepts an 8-bit instruction from fetch and decodes it.
- Reads two operands from an internal 4x8 register file and sign-extends the immediate.
- Registers readdata1, readdata2, sign_extended, alusrc and control bits toward the ALU/memory stages over a valid/ready handshake; takes the write-back port from the last stage.

Parameters:
- NREG, 4, number of architectural registers (index width 2; the instruction format requires 4).
- DW, 8, datapath width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  instruction valid from fetch
- in_ready  output  1  decode can accept an instruction this cycle
- instr  input  8  instruction {op[7:6], rs[5:4], rt[3:2], imm/rd[1:0]}
- wb_en  input  1  register write-back enable
- wb_addr  input  2  write-back register index
- wb_data  input  8  write-back data
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  ALU stage consumes bundle
- readdata1  output  8  R[rs]
- readdata2  output  8  R[rt]
- sign_extended  output  8  sign-extended immediate
- alusrc  output  1  1: ALU uses sign_extended; 0: ALU uses readdata2
- dest  output  2  destination register index
- regwrite  output  1  instruction writes a register
- memread  output  1  load
- memwrite  output  1  store
- jump  output  1  jump

Behaviour:
- Reset (async, immediate): all registers R0..R3 = 0x00. out_valid = 0 and every bundle output = 0. in_ready = 1 once reset deasserts.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational, single output register, no skid buffer).
  - Accept occurs when in_valid && in_ready. Bundle appears the next cycle with out_valid = 1.
  - Latency is 1 cycle. Throughput is 1 instruction/cycle when out_ready stays high.
  - out_valid clears after out_ready is sampled high if no new accept occurs in that cycle.
- Decode, by op:
  - 00 add: alusrc=0, regwrite=1, dest=instr[1:0].
  - 01 lw: alusrc=1, memread=1, regwrite=1, dest=rt.
  - 10 sw: alusrc=1, memwrite=1, regwrite=0, dest=rt (don't-care).
  - 11 j: alusrc=1, jump=1, regwrite=0, sign_extended = sext(instr[5:0]).
- Sign extension: for ops 00/01/10, sign_extended = {6{instr[1]}, instr[1:0]}. For op 11, {2{instr[5]}, instr[5:0]}.
- Register file write: on the clk edge when wb_en=1, R[wb_addr] <= wb_data. All registers are writable; there is no hard-wired zero register.
- Write-to-read bypass: at accept, if wb_en && wb_addr==rs, readdata1 captures wb_data rather than the stale R[rs]. The same rule applies to rt for readdata2.
- Operand refresh while stalled:
  - Condition: out_valid && !out_ready.
  - If wb_en and wb_addr equals the held rs, readdata1 updates to wb_data. Same for rt and readdata2.
  - Held control fields never change.
- Simultaneous out_ready and accept: the new bundle replaces the old one in the same edge, and out_valid stays 1.
- in_valid with in_ready=0: the instruction is ignored, and fetch must hold it stable.
- Reset mid-stall: the bundle is discarded and the register file cleared. No partial write completes.

Decomposition:
- Shared package:
  - opcode constants OP_ADD=2'b00, OP_LW=2'b01, OP_SW=2'b10, OP_J=2'b11
  - field position constants
  - DW/register-index width constants
- Sub-module regfile4x8: two combinational read ports, one synchronous write port, async reset. Bypass and refresh logic stay in decode_stage.

Test Plan:
- Reset: assert reset mid-cycle -> out_valid=0 immediately. After release in_ready=1, and an add reading any register returns 0x00.
- Add: write R1=0x05, R2=0x03 via wb; then instr=0x1B accepted -> next cycle out_valid=1, readdata1=0x05, readdata2=0x03, alusrc=0, dest=3, regwrite=1.
- Load: instr=0x5A with R1=0x10 -> sign_extended=0xFE, alusrc=1, memread=1, regwrite=1, dest=2, readdata1=0x10.
- Bypass: wb_en=1, wb_addr=1, wb_data=0x7F in the same cycle as accepting 0x1B -> readdata1=0x7F.
- Stall: out_ready=0 with bundle held, wb R2=0x11 -> readdata2 becomes 0x11 next cycle, in_ready=0, and the new instr is not accepted until out_ready=1.
- Jump and back-to-back: instr=0xE0 -> sign_extended=0xE0, jump=1, regwrite=0. Three instructions with in_valid=out_ready=1 continuously -> three consecutive valid bundles, no bubbles.

Source files
------------

// File: rtl/decode_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_pkg
// Description : Shared constants for the decode stage of the 8-bit processor.
//               Contains the opcode encodings, the instruction field positions
//               and the datapath and register-index widths.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_stage_pkg;

  // Datapath and register-index widths
  localparam int DW_DEF   = 8;
  localparam int NREG_DEF = 4;
  localparam int RW       = 2;

  // Opcode encodings, taken from instr[7:6]
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  // Instruction field positions: {op[7:6], rs[5:4], rt[3:2], imm/rd[1:0]}
  localparam int OP_LSB  = 6;
  localparam int RS_LSB  = 4;
  localparam int RT_LSB  = 2;
  localparam int IMM_LSB = 0;

endpackage : decode_stage_pkg
`default_nettype wire

// File: rtl/regfile4x8.sv
`default_nettype none
// ============================================================================
// Module      : regfile4x8
// Description : Small architectural register file. Two combinational read
//               ports, one synchronous write port, asynchronous clear.
//               Every register is writable (no hard-wired zero).
// Ports       : clk, reset        - clock, async active-high reset
//               i_we/i_waddr/i_wdata - write port
//               i_raddr1/o_rdata1 - read port 1
//               i_raddr2/o_rdata2 - read port 2
// Revision    : 1.0 - initial release
// ============================================================================
module regfile4x8
  import decode_stage_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_we,
  input  logic [RW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [RW-1:0] i_raddr1,
  output logic [DW-1:0] o_rdata1,
  input  logic [RW-1:0] i_raddr2,
  output logic [DW-1:0] o_rdata2
);

  logic [DW-1:0] r_mem [NREG];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = r_mem[i_raddr1];
  assign o_rdata2 = r_mem[i_raddr2];

endmodule : regfile4x8
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : Instruction decode stage ahead of the ALU. Decodes an 8-bit
//               instruction, reads two operands from the register file,
//               sign-extends the immediate and registers the bundle toward
//               the ALU over a valid/ready handshake (single output register).
// Ports       : clk, reset                  - clock, async active-high reset
//               in_valid/in_ready/instr     - instruction from fetch
//               wb_en/wb_addr/wb_data       - register write-back
//               out_valid/out_ready         - bundle handshake to the ALU
//               readdata1, readdata2, sign_extended, alusrc, dest,
//               regwrite, memread, memwrite, jump - decoded bundle
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int DW   = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    instr,
  input  logic          wb_en,
  input  logic [RW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] readdata1,
  output logic [DW-1:0] readdata2,
  output logic [DW-1:0] sign_extended,
  output logic          alusrc,
  output logic [RW-1:0] dest,
  output logic          regwrite,
  output logic          memread,
  output logic          memwrite,
  output logic          jump
);

  // Instruction fields
  logic [1:0]    w_op;
  logic [RW-1:0] w_rs;
  logic [RW-1:0] w_rt;
  logic [1:0]    w_imm;

  assign w_op  = instr[OP_LSB  +: 2];
  assign w_rs  = instr[RS_LSB  +: RW];
  assign w_rt  = instr[RT_LSB  +: RW];
  assign w_imm = instr[IMM_LSB +: 2];

  // Register file
  logic [DW-1:0] w_rf_rd1;
  logic [DW-1:0] w_rf_rd2;

  regfile4x8 #(
    .NREG (NREG),
    .DW   (DW)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .i_we     (wb_en),
    .i_waddr  (wb_addr),
    .i_wdata  (wb_data),
    .i_raddr1 (w_rs),
    .o_rdata1 (w_rf_rd1),
    .i_raddr2 (w_rt),
    .o_rdata2 (w_rf_rd2)
  );

  // Bundle registers; r_rs/r_rt remember the held sources for refresh
  logic          r_valid;
  logic [DW-1:0] r_rd1;
  logic [DW-1:0] r_rd2;
  logic [DW-1:0] r_sext;
  logic          r_alusrc;
  logic [RW-1:0] r_dest;
  logic          r_regwrite;
  logic          r_memread;
  logic          r_memwrite;
  logic          r_jump;
  logic [RW-1:0] r_rs;
  logic [RW-1:0] r_rt;

  logic w_accept;
  logic w_stall;

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_stall  = r_valid && !out_ready;

  // A write landing on this edge is newer than the register file contents,
  // so it is forwarded into the captured operands.
  logic [DW-1:0] w_rd1;
  logic [DW-1:0] w_rd2;

  assign w_rd1 = (wb_en && (wb_addr == w_rs)) ? wb_data : w_rf_rd1;
  assign w_rd2 = (wb_en && (wb_addr == w_rt)) ? wb_data : w_rf_rd2;

  // Control decode
  logic [DW-1:0] w_sext;
  logic          w_alusrc;
  logic [RW-1:0] w_dest;
  logic          w_regwrite;
  logic          w_memread;
  logic          w_memwrite;
  logic          w_jump;

  always_comb begin
    w_sext     = {{(DW-2){w_imm[1]}}, w_imm};
    w_alusrc   = 1'b1;
    w_dest     = w_rt;
    w_regwrite = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_jump     = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_alusrc   = 1'b0;
        w_regwrite = 1'b1;
        w_dest     = w_imm;
      end
      OP_LW: begin
        w_memread  = 1'b1;
        w_regwrite = 1'b1;
      end
      OP_SW: begin
        w_memwrite = 1'b1;
      end
      OP_J: begin
        w_jump = 1'b1;
        w_sext = {{(DW-6){instr[5]}}, instr[5:0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_rd1      <= '0;
      r_rd2      <= '0;
      r_sext     <= '0;
      r_alusrc   <= 1'b0;
      r_dest     <= '0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_jump     <= 1'b0;
      r_rs       <= '0;
      r_rt       <= '0;
    end else if (w_accept) begin
      r_valid    <= 1'b1;
      r_rd1      <= w_rd1;
      r_rd2      <= w_rd2;
      r_sext     <= w_sext;
      r_alusrc   <= w_alusrc;
      r_dest     <= w_dest;
      r_regwrite <= w_regwrite;
      r_memread  <= w_memread;
      r_memwrite <= w_memwrite;
      r_jump     <= w_jump;
      r_rs       <= w_rs;
      r_rt       <= w_rt;
    end else begin
      if (out_ready) begin
        r_valid <= 1'b0;
      end
      // Keep held operands coherent with write-back while the ALU stalls
      if (w_stall && wb_en && (wb_addr == r_rs)) begin
        r_rd1 <= wb_data;
      end
      if (w_stall && wb_en && (wb_addr == r_rt)) begin
        r_rd2 <= wb_data;
      end
    end
  end

  assign out_valid     = r_valid;
  assign readdata1     = r_rd1;
  assign readdata2     = r_rd2;
  assign sign_extended = r_sext;
  assign alusrc        = r_alusrc;
  assign dest          = r_dest;
  assign regwrite      = r_regwrite;
  assign memread       = r_memread;
  assign memwrite      = r_memwrite;
  assign jump          = r_jump;

endmodule : decode_stage
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Self-checking bench for decode_stage. A behavioural model
//               tracks the register file and the held instruction; a
//               negedge compare process checks all outputs each cycle.
//               Directed scenarios add literal expectations, followed by
//               randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] instr = 8'h00;
  logic       wb_en = 1'b0;
  logic [1:0] wb_addr = 2'd0;
  logic [7:0] wb_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] readdata1;
  logic [7:0] readdata2;
  logic [7:0] sign_extended;
  logic       alusrc;
  logic [1:0] dest;
  logic       regwrite;
  logic       memread;
  logic       memwrite;
  logic       jump;

  decode_stage dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .instr         (instr),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .readdata1     (readdata1),
    .readdata2     (readdata2),
    .sign_extended (sign_extended),
    .alusrc        (alusrc),
    .dest          (dest),
    .regwrite      (regwrite),
    .memread       (memread),
    .memwrite      (memwrite),
    .jump          (jump)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The held bundle's operands always equal the current register contents
  // of its sources (capture includes same-edge writes, stall refresh keeps
  // them current), so the model stores only the instruction and registers.
  logic [7:0] m_regs [4];
  logic       m_valid;
  logic [7:0] m_instr;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
      m_valid = 1'b0;
      m_instr = 8'h00;
    end else begin
      automatic logic acc = in_valid && (!m_valid || out_ready);
      if (wb_en) m_regs[wb_addr] = wb_data;
      if (acc) begin
        m_valid = 1'b1;
        m_instr = instr;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
    if (m_valid) begin
      automatic int op = int'(m_instr[7:6]);
      automatic int sx = (op == 3) ? int'($signed(m_instr[5:0])) : int'($signed(m_instr[1:0]));
      chk("readdata1", {24'd0, readdata1}, {24'd0, m_regs[m_instr[5:4]]});
      chk("readdata2", {24'd0, readdata2}, {24'd0, m_regs[m_instr[3:2]]});
      chk("sign_extended", {24'd0, sign_extended}, sx & 32'hFF);
      chk("alusrc", {31'd0, alusrc}, (op != 0) ? 32'd1 : 32'd0);
      chk("regwrite", {31'd0, regwrite}, (op < 2) ? 32'd1 : 32'd0);
      chk("memread", {31'd0, memread}, (op == 1) ? 32'd1 : 32'd0);
      chk("memwrite", {31'd0, memwrite}, (op == 2) ? 32'd1 : 32'd0);
      chk("jump", {31'd0, jump}, (op == 3) ? 32'd1 : 32'd0);
      if (op == 0) chk("dest_add", {30'd0, dest}, {30'd0, m_instr[1:0]});
      else if (op != 3) chk("dest_rt", {30'd0, dest}, {30'd0, m_instr[3:2]});
    end
  end

  // ---------------- stimulus ----------------
  logic was_acc;

  task automatic cyc();
    @(negedge clk);
    was_acc = in_valid && in_ready;
    @(posedge clk);
    #2;
  endtask

  task automatic wb(input logic [1:0] a, input logic [7:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    cyc();
    wb_en = 1'b0;
  endtask

  initial begin
    // Reset state
    cyc(); cyc();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_readdata1", {24'd0, readdata1}, 32'd0);
    chk("rst_sext", {24'd0, sign_extended}, 32'd0);
    chk("rst_ctrl", {27'd0, alusrc, regwrite, memread, memwrite, jump}, 32'd0);
    reset = 1'b0;
    cyc();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Add reading cleared registers
    in_valid = 1'b1; instr = 8'h1B;
    cyc();
    in_valid = 1'b0;
    chk("add0_rd1", {24'd0, readdata1}, 32'h00);
    chk("add0_rd2", {24'd0, readdata2}, 32'h00);

    // Add
    wb(2'd1, 8'h05);
    wb(2'd2, 8'h03);
    in_valid = 1'b1; instr = 8'h1B;
    cyc();
    in_valid = 1'b0;
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_rd1", {24'd0, readdata1}, 32'h05);
    chk("add_rd2", {24'd0, readdata2}, 32'h03);
    chk("add_alusrc", {31'd0, alusrc}, 32'd0);
    chk("add_dest", {30'd0, dest}, 32'd3);
    chk("add_regwrite", {31'd0, regwrite}, 32'd1);

    // Load
    wb(2'd1, 8'h10);
    in_valid = 1'b1; instr = 8'h5A;
    cyc();
    chk("lw_sext", {24'd0, sign_extended}, 32'hFE);
    chk("lw_ctrl", {29'd0, alusrc, memread, regwrite}, 32'b111);
    chk("lw_dest", {30'd0, dest}, 32'd2);
    chk("lw_rd1", {24'd0, readdata1}, 32'h10);

    // Bypass at accept
    instr = 8'h1B; wb_en = 1'b1; wb_addr = 2'd1; wb_data = 8'h7F;
    cyc();
    wb_en = 1'b0; in_valid = 1'b0;
    chk("byp_rd1", {24'd0, readdata1}, 32'h7F);
    chk("byp_rd2", {24'd0, readdata2}, 32'h03);
    cyc();

    // Stall with refresh
    in_valid = 1'b1; instr = 8'h1B; out_ready = 1'b0;
    cyc();
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    instr = 8'h5A; wb_en = 1'b1; wb_addr = 2'd2; wb_data = 8'h11;
    cyc();
    wb_en = 1'b0;
    chk("stall_rd2", {24'd0, readdata2}, 32'h11);
    chk("stall_alusrc", {31'd0, alusrc}, 32'd0);
    cyc();
    chk("stall_hold_memread", {31'd0, memread}, 32'd0);
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("unstall_memread", {31'd0, memread}, 32'd1);
    chk("unstall_rd2", {24'd0, readdata2}, 32'h11);

    // Jump
    in_valid = 1'b1; instr = 8'hE0;
    cyc();
    chk("j_sext", {24'd0, sign_extended}, 32'hE0);
    chk("j_jump", {31'd0, jump}, 32'd1);
    chk("j_regwrite", {31'd0, regwrite}, 32'd0);

    // Back-to-back
    instr = 8'h1B; cyc();
    chk("b2b0", {30'd0, out_valid, alusrc}, 32'b10);
    instr = 8'h5A; cyc();
    chk("b2b1", {30'd0, out_valid, memread}, 32'b11);
    instr = 8'hA6; cyc();
    chk("b2b2", {30'd0, out_valid, memwrite}, 32'b11);
    in_valid = 1'b0;
    cyc();

    // Reset mid-stall
    in_valid = 1'b1; instr = 8'h1B; out_ready = 1'b0;
    cyc();
    in_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_rd1", {24'd0, readdata1}, 32'd0);
    cyc();
    reset = 1'b0;
    cyc();
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1; in_valid = 1'b1; instr = 8'h1B;
    cyc();
    in_valid = 1'b0;
    chk("midrst_add_rd1", {24'd0, readdata1}, 32'h00);
    chk("midrst_add_rd2", {24'd0, readdata2}, 32'h00);

    // Randomized traffic; fetch holds an unaccepted instruction stable
    for (int n = 0; n < 3000; n++) begin
      if (!(in_valid && !was_acc)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        instr    = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      wb_en     = ($urandom_range(0, 1) != 0);
      wb_addr   = 2'($urandom);
      wb_data   = 8'($urandom);
      cyc();
    end
    in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_decode_stage
`default_nettype wire
